seq_pattern_det: RTL and testbench
==================================

# seq_pattern_det

Parametrised character-stream sequence detector, the generalised successor of the fixed four-symbol ASCII pattern FSM. It accepts a qualified stream of CW-bit characters, compares the last LEN accepted characters against a compile-time pattern, and raises a one-cycle match pulse. Overlap and non-overlap modes are selected at run time, and a saturating match counter is kept. It sits between a UART/byte-stream receiver and control logic that reacts to command strings.

## Interface
- CW, 7: character width in bits.
- LEN, 4: pattern length in characters, 1..16.
- PATTERN, {"R","A","R","A"} packed to CW*LEN bits: first-expected character in the most significant CW bits.
- CNT_W, 8: match counter width.
- WILD, 7'h3F: wildcard character code, used only with WILDCARD_EN.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_char is accepted on this edge.
- in_char  in  CW  input character.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled on each accepted character.
- clear  in  1  synchronous clear of history, match and counter.
- match  out  1  registered one-cycle pulse; pattern completed by the previous accepted character.
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  sticky; match_cnt has saturated.

## Operation
- State:
  - win: LEN-entry character shift window.
  - fill: 0..LEN, number of valid window entries.
  - match, match_cnt, cnt_sat.
- Reset values: win = 0, fill = 0, match = 0, match_cnt = 0, cnt_sat = 0.
- Accept (in_valid = 1, clear = 0):
  - win_next = {win[LEN-2:0], in_char}; for LEN = 1, win_next = in_char.
  - fill_next = min(fill + 1, LEN).
- hit = (fill_next == LEN) and every position of win_next equals the corresponding PATTERN position.
- On hit:
  - match <= 1.
  - match_cnt increments unless it is all-ones; an increment that reaches all-ones sets cnt_sat.
  - overlap = 1: fill stays LEN, so a suffix of this match can begin the next one.
  - overlap = 0: fill <= 0, and the next match needs LEN fresh characters.
- No hit on an accepted character: match <= 0; window and fill update normally.
- in_valid = 0: win, fill and counter hold; match <= 0.
- clear = 1:
  - fill, match, match_cnt and cnt_sat go to 0.
  - win contents are don't-care.
  - clear has priority over a simultaneous in_valid; that character is dropped.
- A change of overlap mid-stream affects only the next hit evaluation. No hit already in progress is retroactively cancelled.
- Comparison is exact over all CW bits. There is no case folding.

## Timing
- Latency: match is high in the cycle immediately after the clk edge that accepts the completing character. It is high for exactly one cycle per hit.
- Back-to-back accepted characters can produce match on consecutive cycles. Example: overlap = 1 with a pattern of all-identical characters.
- match_cnt and cnt_sat update on the same edge as match.
- Asynchronous rst clears all state immediately, including mid-pattern. The first accepted character after rst deassertion counts as window position 1.
- Bubbles in in_valid do not break a partial match; only accepted characters are counted.

## Configuration
- WILDCARD_EN:
  - Defined: any PATTERN position equal to WILD matches every in_char value.
  - Undefined: WILD has no special meaning and is compared literally like any other character.

## Test plan
- Reset/idle: assert rst mid-stream after "RAR" -> all outputs 0; then "A" alone -> no match. Full "RARA" afterwards -> match one cycle after the final A, match_cnt = 1.
- Overlap: overlap = 1, stream "RARARA" with continuous valid -> match after the 4th and 6th characters, match_cnt = 2.
- Non-overlap: overlap = 0, stream "RARARARA" -> match after the 4th and 8th characters only, match_cnt = 2.
- Bubbles and clear: "RA", in_valid low 3 cycles, "RA" -> one match. Then clear asserted together with in_valid and 'R' -> match_cnt = 0, fill = 0, the 'R' is ignored.
- Saturation: CNT_W = 2, eight matches -> match_cnt sticks at 3, cnt_sat = 1 from the third match; clear -> both 0.
- Wildcard: PATTERN "R?RA".
  - WILDCARD_EN defined: "RXRA" -> match.
  - WILDCARD_EN undefined: "RXRA" -> no match; literal "R?RA" -> match.

Source files
------------

// File: rtl/seq_pattern_det.sv
// Sliding-window character pattern detector with overlap/non-overlap modes and a saturating match counter.
// Build with WILDCARD_EN defined to make PATTERN positions equal to WILD match any character.
module seq_pattern_det #(
   parameter int              CW      = 7,
   parameter int              LEN     = 4,
   parameter logic [CW*LEN-1:0] PATTERN = {7'h52, 7'h41, 7'h52, 7'h41},
   parameter int              CNT_W   = 8,
   parameter logic [CW-1:0]   WILD    = 7'h3F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [CW-1:0]    in_char,
   input  logic             overlap,
   input  logic             clear,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

`ifdef WILDCARD_EN
   localparam logic WC_ON = 1'b1;
`else
   localparam logic WC_ON = 1'b0;
`endif

   localparam int FW = $clog2(LEN + 1);

   logic [CW*LEN-1:0] win;
   logic [CW*LEN-1:0] win_next;
   logic [FW-1:0]     fill;
   logic [FW-1:0]     fill_next;
   logic              hit;

   // Newest character lives in the least significant slot, matching PATTERN's MSB-first order.
   generate
      if (LEN == 1) begin : g_win1
         assign win_next = in_char;
      end else begin : g_winn
         assign win_next = {win[CW*(LEN-1)-1:0], in_char};
      end
   endgenerate

   assign fill_next = (fill == FW'(LEN)) ? fill : fill + 1'b1;

   always_comb begin
      hit = (fill_next == FW'(LEN));
      for (int i = 0; i < LEN; i++) begin
         if (!(WC_ON && (PATTERN[i*CW +: CW] == WILD)) &&
             (win_next[i*CW +: CW] != PATTERN[i*CW +: CW]))
            hit = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win       <= '0;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (clear) begin
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (in_valid) begin
         win   <= win_next;
         match <= hit;
         if (hit) begin
            // Non-overlap discards the whole window so the next match needs LEN fresh characters.
            fill <= overlap ? fill_next : '0;
            if (match_cnt != '1) begin
               match_cnt <= match_cnt + 1'b1;
               if (CNT_W'(match_cnt + 1'b1) == '1)
                  cnt_sat <= 1'b1;
            end
         end else begin
            fill <= fill_next;
         end
      end else begin
         match <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed bench for seq_pattern_det: default RARA instance, a 2-bit-counter instance and an "R?RA" instance.
module tb_seq_pattern_det;

`ifdef WILDCARD_EN
   localparam logic WC_EXP = 1'b1;
`else
   localparam logic WC_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [6:0] in_char;
   logic       overlap;
   logic       clear;

   logic       match,   cnt_sat;
   logic [7:0] match_cnt;
   logic       s_match, s_sat;
   logic [1:0] s_cnt;
   logic       w_match, w_sat;
   logic [7:0] w_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_pattern_det u_main (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .overlap(overlap),
      .clear(clear), .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat));

   seq_pattern_det #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .overlap(overlap),
      .clear(clear), .match(s_match), .match_cnt(s_cnt), .cnt_sat(s_sat));

   seq_pattern_det #(.PATTERN({7'h52, 7'h3F, 7'h52, 7'h41})) u_wild (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .overlap(overlap),
      .clear(clear), .match(w_match), .match_cnt(w_cnt), .cnt_sat(w_sat));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs; returns 1 time unit after the edge.
   task automatic step(input logic v, input byte c, input logic clr);
      in_valid = v;
      in_char  = c[6:0];
      clear    = clr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic send(input byte c);
      step(1'b1, c, 1'b0);
   endtask

   initial begin
      string s;
      rst = 1'b1; in_valid = 1'b0; in_char = '0; overlap = 1'b1; clear = 1'b0;
      @(posedge clk); #1;
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_cnt",   32'(match_cnt), 32'd0);
      chk("rst_sat",   32'(cnt_sat), 32'd0);
      rst = 1'b0;

      // Async reset mid-pattern kills the partial "RAR".
      send("R"); send("A"); send("R");
      chk("pre_rst_match", 32'(match), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_match", 32'(match), 32'd0);
      chk("arst_cnt",   32'(match_cnt), 32'd0);
      #1 rst = 1'b0;
      send("A");
      chk("after_rst_A", 32'(match), 32'd0);
      send("R"); send("A"); send("R");
      chk("arar_nomatch", 32'(match), 32'd0);
      send("A");
      chk("rara_match", 32'(match), 32'd1);
      chk("rara_cnt",   32'(match_cnt), 32'd1);
      step(1'b0, "A", 1'b0);
      chk("pulse_one_cycle", 32'(match), 32'd0);

      // Overlap: RARARA matches at 4 and 6.
      step(1'b0, "R", 1'b1);
      chk("clear_cnt", 32'(match_cnt), 32'd0);
      overlap = 1'b1;
      s = "RARARA";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         chk($sformatf("ovl_ch%0d", i + 1), 32'(match), 32'((i == 3) || (i == 5)));
      end
      chk("ovl_cnt", 32'(match_cnt), 32'd2);

      // Non-overlap: RARARARA matches at 4 and 8 only.
      step(1'b0, "R", 1'b1);
      overlap = 1'b0;
      s = "RARARARA";
      for (int i = 0; i < s.len(); i++) begin
         send(s[i]);
         chk($sformatf("novl_ch%0d", i + 1), 32'(match), 32'((i == 3) || (i == 7)));
      end
      chk("novl_cnt", 32'(match_cnt), 32'd2);

      // Bubbles do not break a partial match.
      step(1'b0, "R", 1'b1);
      overlap = 1'b1;
      send("R"); send("A");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, "R", 1'b0);
         chk("bubble_match", 32'(match), 32'd0);
      end
      send("R");
      chk("bubble_R", 32'(match), 32'd0);
      send("A");
      chk("bubble_match_hit", 32'(match), 32'd1);
      chk("bubble_cnt", 32'(match_cnt), 32'd1);

      // Clear wins over a simultaneous valid 'R'; that R must not seed the window.
      step(1'b1, "R", 1'b1);
      chk("clr_valid_match", 32'(match), 32'd0);
      chk("clr_valid_cnt",   32'(match_cnt), 32'd0);
      send("A"); send("R"); send("A");
      chk("clr_dropped_R", 32'(match), 32'd0);
      send("R");
      chk("clr_arar", 32'(match), 32'd0);
      send("A");
      chk("clr_then_match", 32'(match), 32'd1);
      chk("clr_then_cnt",   32'(match_cnt), 32'd1);

      // Saturation on the 2-bit counter instance: eight overlapped matches.
      step(1'b0, "R", 1'b1);
      overlap = 1'b1;
      send("R"); send("A");
      for (int m = 1; m <= 8; m++) begin
         send("R"); send("A");
         chk($sformatf("sat_match%0d", m), 32'(s_match), 32'd1);
         chk($sformatf("sat_cnt%0d", m), 32'(s_cnt), 32'((m < 3) ? m : 3));
         chk($sformatf("sat_flag%0d", m), 32'(s_sat), 32'(m >= 3));
      end
      chk("wide_cnt8", 32'(match_cnt), 32'd8);
      chk("wide_sat8", 32'(cnt_sat), 32'd0);
      step(1'b0, "R", 1'b1);
      chk("sat_clr_cnt", 32'(s_cnt), 32'd0);
      chk("sat_clr_flag", 32'(s_sat), 32'd0);

      // Wildcard pattern R?RA.
      s = "RXRA";
      for (int i = 0; i < s.len(); i++) send(s[i]);
      chk("wild_rxra",  32'(w_match), 32'(WC_EXP));
      chk("main_rxra",  32'(match), 32'd0);
      step(1'b0, "R", 1'b1);
      s = "R?RA";
      for (int i = 0; i < s.len(); i++) send(s[i]);
      chk("wild_literal", 32'(w_match), 32'd1);
      chk("wild_cnt",     32'(w_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
